// File: rtl/vigna_clint_pkg.sv
// Shared definitions for the vigna core-local interruptor: register offsets,
// bus FSM states, reset values and the byte-strobe merge helper.
package vigna_clint_pkg;

    localparam logic [7:0] OFF_MSIP        = 8'h00;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] OFF_MTIME_LO    = 8'h10;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h14;
    localparam logic [7:0] OFF_PRESCALE    = 8'h18;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_ACK   = 2'd1,
        BUS_DRAIN = 2'd2
    } bus_state_t;

    // Bytes without a strobe keep their previous contents.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) result[8*i +: 8] = wdata[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/vigna_clint_timer.sv
// Prescaled 64-bit mtime counter, mtimecmp register and the registered
// timer interrupt comparison.
module vigna_clint_timer
    import vigna_clint_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mtime_lo_we,
    input  logic                  mtime_hi_we,
    input  logic                  mtimecmp_lo_we,
    input  logic                  mtimecmp_hi_we,
    input  logic                  prescale_we,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    output logic [63:0]           mtime,
    output logic [63:0]           mtimecmp,
    output logic [PRESCALE_W-1:0] prescale,
    output logic                  timer_irq
);

    logic [PRESCALE_W-1:0] presc_cnt;
    logic [31:0]           prescale_word;
    logic [31:0]           prescale_new;
    logic                  tick;

    always_comb begin
        prescale_word                   = '0;
        prescale_word[PRESCALE_W-1:0]   = prescale;
        prescale_new                    = apply_wstrb(prescale_word, wdata, wstrb);
    end

    assign tick = (presc_cnt == prescale) && !prescale_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale  <= '0;
            presc_cnt <= '0;
        end else if (prescale_we) begin
            prescale  <= prescale_new[PRESCALE_W-1:0];
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // A bus write to either half of mtime takes priority and drops that cycle's tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime <= '0;
        end else if (mtime_lo_we) begin
            mtime[31:0] <= apply_wstrb(mtime[31:0], wdata, wstrb);
        end else if (mtime_hi_we) begin
            mtime[63:32] <= apply_wstrb(mtime[63:32], wdata, wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtimecmp <= MTIMECMP_RST;
        end else if (mtimecmp_lo_we) begin
            mtimecmp[31:0] <= apply_wstrb(mtimecmp[31:0], wdata, wstrb);
        end else if (mtimecmp_hi_we) begin
            mtimecmp[63:32] <= apply_wstrb(mtimecmp[63:32], wdata, wstrb);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_irq <= 1'b0;
        else       timer_irq <= (mtime >= mtimecmp);
    end

endmodule

// File: rtl/vigna_clint.sv
// Core-local interruptor top: data-bus slave FSM, register decode, MSIP,
// atomic mtime high-half shadow and the external interrupt synchroniser.
module vigna_clint
    import vigna_clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0200_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_valid,
    output logic        bus_ready,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic [3:0]  bus_wstrb,
    output logic [31:0] bus_rdata,
    input  logic        ext_irq_in,
    output logic        ext_irq,
    output logic        timer_irq,
    output logic        soft_irq
);

    bus_state_t            state, next_state;
    logic                  in_window;
    logic                  access;
    logic                  is_write;
    logic [5:0]            word_sel;
    logic [31:0]           read_data;
    logic [31:0]           hi_shadow;
    logic                  ext_sync1;
    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic [PRESCALE_W-1:0] prescale;
    logic                  we_mtime_lo, we_mtime_hi, we_cmp_lo, we_cmp_hi, we_prescale;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^bus_addr[1:0];

    assign in_window = (bus_addr[31:8] == BASE_ADDR[31:8]);
    assign access    = (state == BUS_IDLE) && bus_valid && in_window;
    assign is_write  = |bus_wstrb;
    assign word_sel  = bus_addr[7:2];

    always_comb begin
        we_mtime_lo = 1'b0;
        we_mtime_hi = 1'b0;
        we_cmp_lo   = 1'b0;
        we_cmp_hi   = 1'b0;
        we_prescale = 1'b0;
        if (access && is_write) begin
            we_mtime_lo = (word_sel == OFF_MTIME_LO[7:2]);
            we_mtime_hi = (word_sel == OFF_MTIME_HI[7:2]);
            we_cmp_lo   = (word_sel == OFF_MTIMECMP_LO[7:2]);
            we_cmp_hi   = (word_sel == OFF_MTIMECMP_HI[7:2]);
            we_prescale = (word_sel == OFF_PRESCALE[7:2]);
        end
    end

    always_comb begin
        read_data = '0;
        case (word_sel)
            OFF_MSIP[7:2]:        read_data = {31'b0, soft_irq};
            OFF_MTIMECMP_LO[7:2]: read_data = mtimecmp[31:0];
            OFF_MTIMECMP_HI[7:2]: read_data = mtimecmp[63:32];
            OFF_MTIME_LO[7:2]:    read_data = mtime[31:0];
            OFF_MTIME_HI[7:2]:    read_data = hi_shadow;
            OFF_PRESCALE[7:2]:    read_data[PRESCALE_W-1:0] = prescale;
            default:              read_data = '0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            BUS_IDLE:  if (bus_valid && in_window) next_state = BUS_ACK;
            BUS_ACK:   next_state = BUS_DRAIN;
            BUS_DRAIN: if (!bus_valid) next_state = BUS_IDLE;
            default:   next_state = BUS_IDLE;
        endcase
    end

    // bus_ready is registered off ACK so it rises two edges after the request is raised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= BUS_IDLE;
            bus_ready <= 1'b0;
            bus_rdata <= '0;
        end else begin
            state     <= next_state;
            bus_ready <= (state == BUS_ACK);
            if (access) bus_rdata <= is_write ? 32'h0 : read_data;
        end
    end

    // soft_irq is the MSIP bit itself; a low-half mtime read snapshots the high half.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            soft_irq  <= 1'b0;
            hi_shadow <= '0;
        end else if (access) begin
            if (is_write && word_sel == OFF_MSIP[7:2] && bus_wstrb[0])
                soft_irq <= bus_wdata[0];
            if (!is_write && word_sel == OFF_MTIME_LO[7:2])
                hi_shadow <= mtime[63:32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_sync1 <= 1'b0;
            ext_irq   <= 1'b0;
        end else begin
            ext_sync1 <= ext_irq_in;
            ext_irq   <= ext_sync1;
        end
    end

    vigna_clint_timer #(
        .PRESCALE_W(PRESCALE_W)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .mtime_lo_we   (we_mtime_lo),
        .mtime_hi_we   (we_mtime_hi),
        .mtimecmp_lo_we(we_cmp_lo),
        .mtimecmp_hi_we(we_cmp_hi),
        .prescale_we   (we_prescale),
        .wdata         (bus_wdata),
        .wstrb         (bus_wstrb),
        .mtime         (mtime),
        .mtimecmp      (mtimecmp),
        .prescale      (prescale),
        .timer_irq     (timer_irq)
    );

endmodule
